// File: rtl/tri_fetcher.sv
// Walks a contiguous index range, keeps at most one element-reader request in
// flight, and buffers each returned element (tagged with index and last) in a FIFO.
module tri_fetcher #(
  parameter int NDWORDS    = 9,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [31:0]             first_idx,
  input  logic [31:0]             ntris,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             rd_index,
  output logic                    rd_read,
  input  logic                    rd_iready,
  input  logic [32*NDWORDS-1:0]   rd_data,
  input  logic                    rd_ovalid,
  output logic [32*NDWORDS-1:0]   tri_data,
  output logic [31:0]             tri_idx,
  output logic                    tri_last,
  output logic                    tri_valid,
  input  logic                    tri_ready
);
  localparam int ELEMSZ = 32 * NDWORDS;
  localparam int PW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t            state_reg;
  logic [31:0]       cur_idx_reg;
  logic [31:0]       remaining_reg;
  logic              read_reg;
  logic              done_reg;
  logic              abort_pend_reg;

  logic [ELEMSZ-1:0]     data_mem [FIFO_DEPTH];
  logic [31:0]           idx_mem  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem;
  logic [PW-1:0]         wr_ptr_reg;
  logic [PW-1:0]         rd_ptr_reg;
  logic [CW-1:0]         count_reg;
  logic [CW-1:0]         count_next;

  logic cancel;
  logic push;
  logic pop;
  logic room_next;

  // An abort seen while a request is in flight is remembered until the reply lands.
  assign cancel = abort || abort_pend_reg;
  assign push   = (state_reg == WAIT) && rd_ovalid && !cancel;
  assign pop    = tri_valid && tri_ready;

  always_comb begin
    count_next = count_reg;
    if (abort)
      count_next = '0;
    else
      count_next = count_reg + CW'(push) - CW'(pop);
  end

  // The read strobe is only raised once a FIFO slot is guaranteed for its reply.
  assign room_next = (count_next < DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (abort) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= rd_data;
      idx_mem[wr_ptr_reg]  <= cur_idx_reg;
      last_mem[wr_ptr_reg] <= (remaining_reg == 32'd1);
    end
  end

  assign tri_valid = (count_reg != '0);
  assign tri_data  = tri_valid ? data_mem[rd_ptr_reg] : '0;
  assign tri_idx   = tri_valid ? idx_mem[rd_ptr_reg] : '0;
  assign tri_last  = tri_valid && last_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cur_idx_reg    <= '0;
      remaining_reg  <= '0;
      read_reg       <= 1'b0;
      done_reg       <= 1'b0;
      abort_pend_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          abort_pend_reg <= 1'b0;
          if (start && !abort) begin
            if (ntris == 32'd0) begin
              done_reg <= 1'b1;
            end else begin
              cur_idx_reg   <= first_idx;
              remaining_reg <= ntris;
              read_reg      <= room_next;
              state_reg     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          // An accepted request must complete even if abort arrives with it.
          if (read_reg && rd_iready) begin
            read_reg       <= 1'b0;
            abort_pend_reg <= abort;
            state_reg      <= WAIT;
          end else if (abort) begin
            read_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            read_reg <= room_next;
          end
        end
        WAIT: begin
          if (rd_ovalid) begin
            abort_pend_reg <= 1'b0;
            if (cancel) begin
              state_reg <= IDLE;
            end else if (remaining_reg == 32'd1) begin
              state_reg <= DRAIN;
            end else begin
              cur_idx_reg   <= cur_idx_reg + 32'd1;
              remaining_reg <= remaining_reg - 32'd1;
              read_reg      <= room_next;
              state_reg     <= ISSUE;
            end
          end else if (abort) begin
            abort_pend_reg <= 1'b1;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (count_reg == '0) begin
            done_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign rd_read  = read_reg;
  assign rd_index = cur_idx_reg;

endmodule

// File: tb/tb_tri_fetcher.sv
// Bench for tri_fetcher: behavioural element reader, scoreboard of expected
// elements, table of runs plus hand-written abort, backpressure and reset cases.
module tb_tri_fetcher;
  localparam int NDW    = 9;
  localparam int DEPTH  = 4;
  localparam int ELEMSZ = 32 * NDW;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [31:0]       first_idx;
  logic [31:0]       ntris;
  logic              abort;
  logic              busy;
  logic              done;
  logic [31:0]       rd_index;
  logic              rd_read;
  logic              rd_iready;
  logic [ELEMSZ-1:0] rd_data;
  logic              rd_ovalid;
  logic [ELEMSZ-1:0] tri_data;
  logic [31:0]       tri_idx;
  logic              tri_last;
  logic              tri_valid;
  logic              tri_ready;

  tri_fetcher #(.NDWORDS(NDW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .first_idx(first_idx), .ntris(ntris),
    .abort(abort), .busy(busy), .done(done), .rd_index(rd_index), .rd_read(rd_read),
    .rd_iready(rd_iready), .rd_data(rd_data), .rd_ovalid(rd_ovalid),
    .tri_data(tri_data), .tri_idx(tri_idx), .tri_last(tri_last),
    .tri_valid(tri_valid), .tri_ready(tri_ready)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_data(input string nm, input logic [ELEMSZ-1:0] act, input logic [ELEMSZ-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [ELEMSZ-1:0] elem_of(input logic [31:0] idx);
    logic [ELEMSZ-1:0] v;
    v = '0;
    for (int k = 0; k < NDW; k++)
      v[k*32 +: 32] = idx * 32'd3 + 32'(k);
    return v;
  endfunction

  // Scoreboard of elements the downstream side must see, in order.
  typedef struct {
    logic [31:0]       idx;
    logic [ELEMSZ-1:0] data;
    logic              last;
  } exp_t;
  exp_t sb[$];
  int   done_count = 0;
  int   extra_pops = 0;

  always begin
    @(negedge clk);
    if (!reset) begin
      if (done)
        done_count++;
      if (tri_valid && tri_ready) begin
        if (sb.size() == 0) begin
          extra_pops++;
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("tri_idx", 64'(tri_idx), 64'(e.idx));
          check_data("tri_data", tri_data, e.data);
          check("tri_last", 64'(tri_last), 64'(e.last));
        end
      end
    end
  end

  // Behavioural element reader: one request at a time, configurable latency,
  // ready gap after each reply and optional stray ovalid pulses while idle.
  int          lat = 2;
  int          gap = 0;
  bit          stray_en = 1'b0;
  bit          pending = 1'b0;
  bit          ov_real = 1'b0;
  bit          idx_moved = 1'b0;
  int          cd = 0;
  int          gap_cnt = 0;
  logic [31:0] pend_idx = '0;
  int          hs_count = 0;
  int          resp_count = 0;

  always begin
    bit          hs;
    bit          rst_s;
    logic [31:0] idx_s;
    @(negedge clk);
    hs    = rd_read && rd_iready;
    rst_s = reset;
    idx_s = rd_index;
    if (pending && (idx_s !== pend_idx))
      idx_moved = 1'b1;
    @(posedge clk);
    #1;
    if (rst_s) begin
      pending   = 1'b0;
      ov_real   = 1'b0;
      rd_ovalid = 1'b0;
      gap_cnt   = 0;
      rd_iready = 1'b1;
    end else begin
      if (!pending && gap_cnt > 0)
        gap_cnt--;
      if (rd_ovalid) begin
        rd_ovalid = 1'b0;
        if (ov_real) begin
          pending = 1'b0;
          ov_real = 1'b0;
          gap_cnt = gap;
        end
      end else if (stray_en && !pending && !hs && $urandom_range(0, 2) == 0) begin
        rd_ovalid = 1'b1;
        rd_data   = {NDW{32'hDEAD_BEEF}};
      end
      if (hs) begin
        hs_count++;
        pending   = 1'b1;
        pend_idx  = idx_s;
        cd        = lat;
        idx_moved = 1'b0;
      end
      if (pending && !ov_real) begin
        cd--;
        if (cd == 0) begin
          check("rd_index_hold", 64'(idx_moved), 64'(0));
          rd_ovalid = 1'b1;
          ov_real   = 1'b1;
          rd_data   = elem_of(pend_idx);
          resp_count++;
        end
      end
      rd_iready = !pending && (gap_cnt == 0);
    end
  end

  bit ready_rand = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (ready_rand)
      tri_ready = ($urandom_range(0, 1) == 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [31:0] f, input logic [31:0] n, input bit do_push);
    if (do_push) begin
      for (int k = 0; k < int'(n); k++) begin
        exp_t e;
        e.idx  = f + 32'(k);
        e.data = elem_of(e.idx);
        e.last = (k == int'(n) - 1);
        sb.push_back(e);
      end
    end
    first_idx = f;
    ntris     = n;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int max, input string nm);
    int n;
    n = 0;
    while (done_count == d0 && n < max) begin
      tick();
      n++;
    end
    check(nm, 64'(done_count == d0), 64'(0));
  endtask

  typedef struct {
    logic [31:0] first;
    logic [31:0] n;
    int          lat;
    int          gap;
    bit          stray;
    bit          rnd_ready;
    int          exp_reads;
    int          exp_dones;
  } run_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    run_t runs [4];
    int   hs0, d0, r0, n;

    runs[0] = '{first: 32'd10,         n: 32'd3, lat: 2,  gap: 0, stray: 1'b0, rnd_ready: 1'b0, exp_reads: 3, exp_dones: 1};
    runs[1] = '{first: 32'hFFFF_FFFF,  n: 32'd2, lat: 2,  gap: 0, stray: 1'b0, rnd_ready: 1'b0, exp_reads: 2, exp_dones: 1};
    runs[2] = '{first: 32'd100,        n: 32'd3, lat: 20, gap: 5, stray: 1'b1, rnd_ready: 1'b0, exp_reads: 3, exp_dones: 1};
    runs[3] = '{first: 32'd50,         n: 32'd6, lat: 1,  gap: 0, stray: 1'b0, rnd_ready: 1'b1, exp_reads: 6, exp_dones: 1};

    reset = 1'b1; start = 1'b0; abort = 1'b0; first_idx = '0; ntris = '0;
    tri_ready = 1'b1; rd_iready = 1'b1; rd_ovalid = 1'b0; rd_data = '0;
    repeat (3) tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_rd_read", 64'(rd_read), 64'(0));
    check("rst_rd_index", 64'(rd_index), 64'(0));
    check("rst_tri_valid", 64'(tri_valid), 64'(0));
    reset = 1'b0;
    repeat (2) tick();

    foreach (runs[i]) begin
      lat = runs[i].lat; gap = runs[i].gap; stray_en = runs[i].stray;
      if (runs[i].rnd_ready) ready_rand = 1'b1;
      else begin ready_rand = 1'b0; tri_ready = 1'b1; end
      hs0 = hs_count; d0 = done_count;
      start_run(runs[i].first, runs[i].n, 1'b1);
      wait_done(d0, 600, "run_timeout");
      ready_rand = 1'b0; tri_ready = 1'b1; stray_en = 1'b0;
      repeat (3) tick();
      check("run_reads", 64'(hs_count - hs0), 64'(runs[i].exp_reads));
      check("run_dones", 64'(done_count - d0), 64'(runs[i].exp_dones));
      check("run_sb_left", 64'(sb.size()), 64'(0));
      check("run_busy_after", 64'(busy), 64'(0));
    end

    // Zero-length run: done the cycle after start, no reads.
    lat = 2; gap = 0;
    hs0 = hs_count; d0 = done_count;
    start_run(32'd5, 32'd0, 1'b1);
    check("zero_done_pulse", 64'(done), 64'(1));
    check("zero_busy", 64'(busy), 64'(0));
    tick();
    check("zero_done_single", 64'(done), 64'(0));
    repeat (5) tick();
    check("zero_reads", 64'(hs_count - hs0), 64'(0));
    check("zero_dones", 64'(done_count - d0), 64'(1));

    // Backpressure: FIFO fills, requests stop, then everything drains in order.
    tri_ready = 1'b0;
    hs0 = hs_count; d0 = done_count;
    start_run(32'd200, 32'd8, 1'b1);
    repeat (40) tick();
    check("bp_reads_stalled", 64'(hs_count - hs0), 64'(4));
    check("bp_rd_read_low", 64'(rd_read), 64'(0));
    check("bp_tri_valid", 64'(tri_valid), 64'(1));
    check("bp_head_idx", 64'(tri_idx), 64'(200));
    check("bp_head_last", 64'(tri_last), 64'(0));
    tri_ready = 1'b1;
    wait_done(d0, 300, "bp_timeout");
    tick();
    check("bp_reads_total", 64'(hs_count - hs0), 64'(8));
    check("bp_sb_left", 64'(sb.size()), 64'(0));

    // Abort while a request is in flight; start while busy is ignored.
    lat = 20;
    hs0 = hs_count; d0 = done_count; r0 = resp_count;
    start_run(32'd300, 32'd4, 1'b0);
    n = 0;
    while (hs_count == hs0 && n < 20) begin tick(); n++; end
    check("abort_req_timeout", 64'(hs_count == hs0), 64'(0));
    abort = 1'b1; tick(); abort = 1'b0;
    first_idx = 32'd999; ntris = 32'd1; start = 1'b1; tick(); start = 1'b0;
    check("abort_busy_waiting", 64'(busy), 64'(1));
    check("abort_index_held", 64'(rd_index), 64'(300));
    n = 0;
    while (busy && n < 60) begin tick(); n++; end
    check("abort_busy_timeout", 64'(busy), 64'(0));
    check("abort_resp_seen", 64'(resp_count - r0), 64'(1));
    check("abort_tri_valid", 64'(tri_valid), 64'(0));
    repeat (10) tick();
    check("abort_reads", 64'(hs_count - hs0), 64'(1));
    check("abort_dones", 64'(done_count - d0), 64'(0));
    check("abort_busy_stays", 64'(busy), 64'(0));

    // Reset with two elements buffered, then a normal run.
    lat = 2; tri_ready = 1'b0;
    r0 = resp_count;
    start_run(32'd40, 32'd6, 1'b1);
    n = 0;
    while ((resp_count - r0) < 2 && n < 40) begin tick(); n++; end
    check("mrst_resp_timeout", 64'((resp_count - r0) < 2), 64'(0));
    tick();
    check("mrst_pre_valid", 64'(tri_valid), 64'(1));
    reset = 1'b1;
    tick();
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_done", 64'(done), 64'(0));
    check("mrst_rd_read", 64'(rd_read), 64'(0));
    check("mrst_rd_index", 64'(rd_index), 64'(0));
    check("mrst_tri_valid", 64'(tri_valid), 64'(0));
    check("mrst_tri_last", 64'(tri_last), 64'(0));
    check("mrst_tri_idx", 64'(tri_idx), 64'(0));
    check_data("mrst_tri_data", tri_data, '0);
    reset = 1'b0;
    sb.delete();
    repeat (3) tick();
    tri_ready = 1'b1;
    hs0 = hs_count; d0 = done_count;
    start_run(32'd7, 32'd2, 1'b1);
    wait_done(d0, 200, "mrst_run_timeout");
    tick();
    check("mrst_run_reads", 64'(hs_count - hs0), 64'(2));
    check("mrst_sb_left", 64'(sb.size()), 64'(0));
    check("extra_pops", 64'(extra_pops), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tri_fetcher.md
# tri_fetcher

Streams a contiguous run of triangle records out of SDRAM by walking an index range and driving the element reader's index/read handshake one request at a time. Each returned element is tagged with its index and a last flag, and is buffered in a small FIFO. The FIFO feeds the downstream ray–triangle intersection stage over a valid/ready stream. The block sits directly upstream of the reader: it produces the reader's `index`/`read` and consumes its `data`/`ovalid`.

## Interface
- `NDWORDS`, 9: 32-bit words per element; must match the reader.
- `FIFO_DEPTH`, 4: output buffer entries; power of two, ≥2.
- `ELEMSZ` (localparam): `32*NDWORDS`.

- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle pulse; begins a run. Honoured only in IDLE.
- `first_idx`  in  32  first element index; sampled on `start`.
- `ntris`  in  32  number of elements to fetch; sampled on `start`.
- `abort`  in  1  cancels the run and empties the FIFO.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `rd_index`  out  32  index presented to the reader.
- `rd_read`  out  1  read strobe to the reader (the reader's ivalid).
- `rd_iready`  in  1  reader input ready.
- `rd_data`  in  ELEMSZ  element returned by the reader.
- `rd_ovalid`  in  1  reader output valid.
- `tri_data`  out  ELEMSZ  FIFO head element.
- `tri_idx`  out  32  index of the FIFO head element.
- `tri_last`  out  1  head element is the last of the run.
- `tri_valid`  out  1  FIFO not empty.
- `tri_ready`  in  1  downstream accepts the head element.

## Operation
- **States:** IDLE, ISSUE, WAIT, DRAIN.
- **IDLE:**
  - On `start` with `ntris==0`: pulse `done` next cycle; stay in IDLE.
  - On `start` otherwise: load `cur_idx=first_idx` and `remaining=ntris`; go to ISSUE.
- **ISSUE:**
  - Issue condition: `rd_iready && fifo_count<FIFO_DEPTH`. When it holds, `rd_read=1` for exactly this cycle, then go to WAIT.
  - Otherwise stay in ISSUE with `rd_read=0`.
- **WAIT:**
  - At most one request is outstanding at any time.
  - `rd_index` holds `cur_idx`, unchanged from ISSUE until `rd_ovalid` is seen.
  - On `rd_ovalid`: push `{rd_data, cur_idx, remaining==1}` into the FIFO.
    - If `remaining==1`: go to DRAIN.
    - Otherwise: `cur_idx+=1`, `remaining-=1`, go to ISSUE.
  - `rd_ovalid` is ignored in every state except WAIT.
- **DRAIN:** when the FIFO is empty, pulse `done` and go to IDLE.
- **FIFO:**
  - Pop on `tri_valid && tri_ready`.
  - A simultaneous push and pop leaves the count unchanged.
  - Push-when-full cannot occur, because ISSUE reserves the slot before requesting.
  - Pop-when-empty is a no-op.
- **Arithmetic:**
  - `cur_idx` is 32-bit and wraps from `FFFFFFFF` to `0`; no error is flagged.
  - `remaining` is a 32-bit down-counter.
- **`start`:** ignored while `busy`.
- **`abort`:**
  - From ISSUE or DRAIN: clear the FIFO and go to IDLE; `done` is not pulsed.
  - From WAIT: go to IDLE once the outstanding `rd_ovalid` arrives and discard that data. The reader must not be left mid-transaction.
- **Reset:** clears state to IDLE, the FIFO count and the pointers, regardless of activity in progress.

## Timing
- **Reset values:** `busy=0`, `done=0`, `rd_read=0`, `rd_index=0`, `tri_valid=0`, `tri_last=0`, `tri_idx=0`, `tri_data=0`.
- **Output drive:** `rd_read` and `rd_index` are driven from the registered state and `cur_idx`, never combinationally from `rd_iready`.
- **Start to first request:** `start` at cycle T gives the first `rd_read` no earlier than T+1.
- **Reader latency:** any latency ≥1 cycle from `rd_read` to `rd_ovalid` is tolerated.
- **Cached element:** the reader's latency is 2 cycles, giving one element per 3 cycles (ISSUE plus 2 WAIT).
- **FIFO output:** `tri_valid` rises the cycle after the push; there is no bypass.
- **`tri_*` stability:** outputs are stable while `tri_valid && !tri_ready`.
- **`done`:** a single-cycle pulse in the cycle the state leaves DRAIN (or the cycle after `start` when `ntris==0`). `busy` falls in the same cycle.

## Test plan
- **Basic run, always-hit reader:** `start`, `first_idx=10`, `ntris=3`, `tri_ready=1`, reader returns data=`idx*3` two cycles after `rd_read` → outputs `tri_idx` 10, 11, 12 with matching data; `tri_last` only on 12; one `done` pulse; exactly 3 `rd_read` pulses.
- **Backpressure:** `ntris=8`, `FIFO_DEPTH=4`, `tri_ready=0` → exactly 4 reads issued, then `rd_read` stays 0; releasing `tri_ready` → remaining 4 elements delivered in order with none lost.
- **Miss latency and `rd_iready` low:** reader returns `ovalid` after 20 cycles and holds `rd_iready=0` for 5 cycles before each accept → `rd_index` constant throughout each wait; stray `rd_ovalid` pulses while in ISSUE are ignored.
- **Edge inputs:** `ntris=0` → `done` at T+1, no `rd_read`. `first_idx=FFFFFFFF`, `ntris=2` → indices `FFFFFFFF` then `00000000`.
- **Abort:**
  - `abort` during WAIT → no further `rd_read`; pending data discarded; `tri_valid=0`; `busy` falls after `rd_ovalid`; no `done`.
  - `start` while busy → ignored.
- **Reset mid-run:** assert `reset` with 2 elements in the FIFO → next cycle all outputs at reset values; a new `start` then runs normally.
